// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: ALU opcodes, arbiter states, datapath width.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; add/sub wrap, slt is unsigned, unused opcodes give zero.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        ALUControl,
  output logic [DATA_W-1:0] Result
);

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_XOR: Result = A ^ B;
      ALU_SLT: Result = {{(DATA_W-1){1'b0}}, (A < B)};
      default: Result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter that time-shares one ALU among NREQ requesters,
// one operation in flight, result returned over a valid/ready handshake.
//
// state | meaning
// IDLE  | arbitrate; accept winner's operands on the edge
// EXEC  | ALU runs on operand registers; result registered at end of cycle
// RESP  | rsp_valid[gnt] high until rsp_ready[gnt]
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][DATA_W-1:0] req_a,
  input  logic [NREQ-1:0][DATA_W-1:0] req_b,
  input  logic [NREQ-1:0][2:0]        req_op,
  output logic [NREQ-1:0]             rsp_valid,
  input  logic [NREQ-1:0]             rsp_ready,
  output logic [DATA_W-1:0]           rsp_result,
  output logic                        busy,
  output logic [CNT_W-1:0]            ops_done
);

  localparam int PW = $clog2(NREQ);

  arb_state_e        state, state_nxt;
  logic [PW-1:0]     ptr, gnt, pick, ptr_nxt;
  logic              any_valid;
  logic [DATA_W-1:0] op_a, op_b, alu_y;
  logic [2:0]        op_c;

  // First asserted valid at or after p, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [PW-1:0] p);
    logic [PW-1:0] idx;
    logic          found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(p) + k) % NREQ);
      if (!found && v[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign any_valid = |req_valid;
  assign pick      = rr_pick(req_valid, ptr);
  assign ptr_nxt   = PW'((int'(pick) + 1) % NREQ);

  alu u_alu (
    .A          (op_a),
    .B          (op_b),
    .ALUControl (op_c),
    .Result     (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt       = EXEC;
          req_ready[pick] = rst_n;
        end
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        busy           = 1'b1;
        rsp_valid[gnt] = 1'b1;
        if (rsp_ready[gnt]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      gnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_c       <= '0;
      rsp_result <= '0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_a <= req_a[pick];
            op_b <= req_b[pick];
            op_c <= req_op[pick];
            gnt  <= pick;
            ptr  <= ptr_nxt;
          end
        end
        EXEC: rsp_result <= alu_y;
        RESP: if (rsp_ready[gnt]) ops_done <= ops_done + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
